// File: rtl/sipo_pkg.sv
// Shared types, constants and helpers for the sipo_deser serial receiver.
package sipo_pkg;

    typedef enum logic {ST_SHIFT, ST_PARITY} sipo_state_t;

    localparam logic PARITY_EVEN = 1'b0;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

    // Odd/even reduction over a zero-extended frame (frames up to 32 bits).
    function automatic logic frame_xor(input logic [31:0] frame);
        return ^frame;
    endfunction

endpackage

// File: rtl/sipo_bit_cnt.sv
// Bit-position counter for the receiver: counts sampled bits, wraps after WIDTH-1.
import sipo_pkg::*;

module sipo_bit_cnt #(
    parameter int WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_inc,
    input  logic                      i_clr,
    output logic [cnt_w(WIDTH)-1:0]   o_cnt,
    output logic                      o_tc
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;

    // Counter register; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_inc) begin
            if (r_cnt == LAST) begin
                r_cnt <= {CW{1'b0}};
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out receiver with a one-entry valid/ready output buffer.
// Define SIPO_PARITY_EN to expect a trailing even-parity bit per frame.
import sipo_pkg::*;

module sipo_deser #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             s_sync,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             p_perr,
    output logic             overrun
);

    sipo_state_t      r_state;
    sipo_state_t      w_next_state;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_p_out;
    logic             r_p_valid;
    logic             r_p_perr;
    logic             r_overrun;

    logic [WIDTH-1:0] w_word;
    logic             w_perr;
    logic             w_complete;
    logic             w_shift_en;
    logic             w_tc;
    logic             w_accept;
    logic [cnt_w(WIDTH)-1:0] w_cnt;

    sipo_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_shift_en),
        .i_clr (s_sync),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    // Next-state, shift enable and word completion for the receive FSM.
    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_complete   = 1'b0;
        w_word       = r_sh;
        w_perr       = 1'b0;
        if (s_sync) begin
            w_next_state = ST_SHIFT;
        end else if (s_valid) begin
            case (r_state)
                ST_SHIFT: begin
                    w_shift_en = 1'b1;
                    if (w_tc) begin
`ifdef SIPO_PARITY_EN
                        w_next_state = ST_PARITY;
`else
                        w_complete   = 1'b1;
                        w_word       = {s_in, r_sh[WIDTH-1:1]};
`endif
                    end else begin
                        w_next_state = ST_SHIFT;
                    end
                end
`ifdef SIPO_PARITY_EN
                // Data bits are already in place; this bit only feeds the check.
                ST_PARITY: begin
                    w_complete   = 1'b1;
                    w_word       = r_sh;
                    w_perr       = (frame_xor(32'({s_in, r_sh})) != PARITY_EVEN);
                    w_next_state = ST_SHIFT;
                end
`endif
                default: begin
                    w_next_state = ST_SHIFT;
                end
            endcase
        end else begin
            w_next_state = r_state;
        end
    end

    // A finished word is kept if the buffer is empty or drains on this edge.
    assign w_accept = w_complete & (~r_p_valid | p_ready);

    // Receive FSM state and shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_SHIFT;
            r_sh    <= {WIDTH{1'b0}};
        end else begin
            r_state <= w_next_state;
            if (w_shift_en) begin
                r_sh <= {s_in, r_sh[WIDTH-1:1]};
            end else begin
                r_sh <= r_sh;
            end
        end
    end

    // Output buffer, parity flag and overrun pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p_out   <= {WIDTH{1'b0}};
            r_p_valid <= 1'b0;
            r_p_perr  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_complete & ~w_accept;
            if (w_accept) begin
                r_p_out   <= w_word;
                r_p_perr  <= w_perr;
                r_p_valid <= 1'b1;
            end else if (r_p_valid & p_ready) begin
                r_p_valid <= 1'b0;
            end else begin
                r_p_valid <= r_p_valid;
            end
        end
    end

    assign p_out   = r_p_out;
    assign p_valid = r_p_valid;
    assign p_perr  = r_p_perr;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser (WIDTH=4): directed scenarios plus random traffic.
module tb_sipo_deser;

    localparam int W = 4;
`ifdef SIPO_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clk;
    logic         rst_n;
    logic         s_in;
    logic         s_valid;
    logic         s_sync;
    logic [W-1:0] p_out;
    logic         p_valid;
    logic         p_ready;
    logic         p_perr;
    logic         overrun;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           bits_q[$];
    logic [W:0]   exp_q[$];   // {perr, word}
    logic         m_full  = 1'b0;
    logic         m_ovr   = 1'b0;
    logic         m_reset = 1'b0;
    logic         m_started = 1'b0;
    logic         done    = 1'b0;

    sipo_deser #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_in    (s_in),
        .s_valid (s_valid),
        .s_sync  (s_sync),
        .p_out   (p_out),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .p_perr  (p_perr),
        .overrun (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the frame rules to one clock edge's inputs.
    task automatic model_step(input logic v, input logic b, input logic sy,
                              input logic rd, input logic rs);
        logic       complete;
        logic [W:0] entry;
        int         x;
        complete = 1'b0;
        entry    = '0;
        if (!rs) begin
            bits_q.delete();
            exp_q.delete();
            m_full  = 1'b0;
            m_ovr   = 1'b0;
            m_reset = 1'b1;
        end else begin
            m_reset = 1'b0;
            if (sy) begin
                bits_q.delete();
            end else if (v) begin
                bits_q.push_back(int'(b));
                if (bits_q.size() == FRAME) begin
                    x = 0;
                    for (int i = 0; i < W; i++) entry[i] = bits_q[i][0];
                    for (int i = 0; i < FRAME; i++) x = x + bits_q[i];
`ifdef SIPO_PARITY_EN
                    entry[W] = (x % 2 != 0);
`else
                    entry[W] = 1'b0;
`endif
                    complete = 1'b1;
                    bits_q.delete();
                end
            end
            m_ovr = 1'b0;
            if (complete) begin
                if (!m_full || rd) begin
                    exp_q.push_back(entry);
                    m_full = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_full && rd) begin
                m_full = 1'b0;
            end
        end
        m_started = 1'b1;
    endtask

    task automatic cyc(input logic v, input logic b, input logic sy,
                       input logic rd, input logic rs);
        s_valid = v; s_in = b; s_sync = sy; p_ready = rd; rst_n = rs;
        @(posedge clk);
        model_step(v, b, sy, rd, rs);
        #1;
    endtask

    // Send n bits of 'bits' LSB first, with 'gap' idle cycles after each.
    task automatic send(input logic [7:0] bits, input int n, input int gap, input logic rd);
        logic [7:0] tmp;
        tmp = bits;
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, tmp[i], 1'b0, rd, 1'b1);
            for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, rd, 1'b1);
        end
    endtask

    task automatic idle(input int n, input logic rd);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, rd, 1'b1);
    endtask

    // Monitor: compares DUT outputs against the model once per cycle.
    initial begin
        logic [W:0] e;
        @(posedge clk);
        while (!done) begin
            @(negedge clk);
            if (m_started) begin
                if (m_reset) begin
                    chk("reset_p_out", 32'(p_out), 32'd0);
                    chk("reset_p_perr", 32'(p_perr), 32'd0);
                end
                chk("p_valid", 32'(p_valid), 32'(m_full));
                chk("overrun", 32'(overrun), 32'(m_ovr));
                if (p_valid === 1'b1 && p_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 32'(p_out), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("p_out", 32'(p_out), 32'(e[W-1:0]));
                        chk("p_perr", 32'(p_perr), 32'(e[W]));
                    end
                end
            end
        end
    end

    initial begin
        s_in = 1'b0; s_valid = 1'b0; s_sync = 1'b0; p_ready = 1'b0; rst_n = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Back-to-back bits 1,0,1,1 (word 4'hD), parity bit 1 when enabled
        send(8'b0001_1101, FRAME, 0, 1'b1);
        idle(3, 1'b1);

        // Same word with idle gaps between bits
        send(8'b0001_1101, FRAME, 2, 1'b1);
        send(8'b0000_0000, 0, 0, 1'b1);
        idle(3, 1'b1);

        // Consumer stalled: second word (4'h6) must be dropped with an overrun
        send(8'b0001_1101, FRAME, 0, 1'b0);
        send(8'b0000_0110, FRAME, 0, 1'b0);
        idle(3, 1'b0);
        idle(3, 1'b1);

        // Resync after two bits; sync beats s_valid
        send(8'b0000_0011, 2, 0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        send(8'b0001_0100, FRAME, 0, 1'b1);
        idle(3, 1'b1);

        // Reset in the middle of a word
        send(8'b0000_0011, 2, 0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(8'b0000_1111, FRAME, 0, 1'b1);
        idle(3, 1'b1);

        // Bad parity (enabled) / fifth bit opens the next word (disabled)
        send(8'b0000_1101, 5, 0, 1'b1);
        send(8'b0000_0111, 3, 0, 1'b1);
        idle(3, 1'b1);

        // Realign before random traffic
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom % 4) != 0, $urandom % 2 == 1, ($urandom % 40) == 0,
                ($urandom % 3) != 0, ($urandom % 300) != 0);
        end

        idle(4, 1'b1);
        done = 1'b1;
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
